// File: rtl/cgra_clk_gate_ctrl.sv
// -----------------------------------------------------------------------------
// cgra_clk_gate_ctrl
//
// Power-management controller for the CGRA clock-gating cell. Lives in the
// always-on clock domain. It enables the CGRA clock when any client requests
// it, and waits a fixed settle time before granting. It holds the clock in ON
// while there is activity. After a programmable idle timeout it gates the
// clock again. It also keeps a saturating count of gated (OFF) cycles.
//
// Parameters:
//   NUM_REQ      number of requesters sharing the CGRA clock
//   WAKE_CYCLES  settle cycles between enable assertion and first grant (>=1)
//   TO_W         width of the idle-timeout value
//   STAT_W       width of the gated-cycle counter
//
// Ports:
//   clk_i           always-on clock
//   rst_i           synchronous, active-high reset
//   req_i           level requests, one per client
//   gnt_o           per-client grant; high only in ON, follows req_i
//   force_on_i      software keep-alive, an anonymous request
//   cgra_busy_i     CGRA datapath busy; ignored while the clock is gated
//   idle_timeout_i  idle cycles before gating; sampled on entry to IDLE
//   clk_en_o        enable to the gating cell, driven straight from a flop
//   state_o         OFF=0, WAKE=1, ON=2, IDLE=3
//   stat_clr_i      synchronous clear of the statistics counter
//   gated_cycles_o  saturating count of cycles spent in OFF
// -----------------------------------------------------------------------------
module cgra_clk_gate_ctrl #(
  parameter int NUM_REQ     = 3,
  parameter int WAKE_CYCLES = 2,
  parameter int TO_W        = 8,
  parameter int STAT_W      = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NUM_REQ-1:0]  req_i,
  output logic [NUM_REQ-1:0]  gnt_o,
  input  logic                force_on_i,
  input  logic                cgra_busy_i,
  input  logic [TO_W-1:0]     idle_timeout_i,
  output logic                clk_en_o,
  output logic [1:0]          state_o,
  input  logic                stat_clr_i,
  output logic [STAT_W-1:0]   gated_cycles_o
);

  // The wake counter only ever holds values 0 .. WAKE_CYCLES-1.
  localparam int              WK_W      = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
  localparam logic [WK_W-1:0] WAKE_LOAD = WK_W'(WAKE_CYCLES - 1);

  if (WAKE_CYCLES < 1) begin : g_bad_wake
    $error("cgra_clk_gate_ctrl: WAKE_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_WAKE = 2'd1,
    ST_ON   = 2'd2,
    ST_IDLE = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [WK_W-1:0]   r_wake_cnt;
  logic [WK_W-1:0]   w_wake_cnt_nxt;
  logic [TO_W-1:0]   r_idle_cnt;
  logic [TO_W-1:0]   w_idle_cnt_nxt;
  logic              r_clk_en;
  logic [STAT_W-1:0] r_gated;

  logic w_any_req;
  logic w_activity;

  assign w_any_req  = (|req_i) | force_on_i;
  assign w_activity = w_any_req | cgra_busy_i;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    w_state_nxt    = r_state;
    w_wake_cnt_nxt = r_wake_cnt;
    w_idle_cnt_nxt = r_idle_cnt;

    unique case (r_state)
      ST_OFF: begin
        // cgra_busy_i is deliberately not looked at: a busy flag from a
        // stopped datapath is meaningless and must not wake the clock.
        if (w_any_req) begin
          w_state_nxt    = ST_WAKE;
          w_wake_cnt_nxt = WAKE_LOAD;
        end
      end

      ST_WAKE: begin
        // Always runs to completion, even if the requester has gone away;
        // ON will then fall through to IDLE on its own.
        if (r_wake_cnt == '0) begin
          w_state_nxt = ST_ON;
        end else begin
          w_wake_cnt_nxt = r_wake_cnt - 1'b1;
        end
      end

      ST_ON: begin
        if (!w_activity) begin
          w_state_nxt    = ST_IDLE;
          w_idle_cnt_nxt = idle_timeout_i;
        end
      end

      ST_IDLE: begin
        // Fresh activity wins over expiry in the same cycle, so the clock
        // never drops for a request that arrives on the last idle cycle.
        if (w_activity) begin
          w_state_nxt = ST_ON;
        end else if (r_idle_cnt == '0) begin
          w_state_nxt = ST_OFF;
        end else begin
          w_idle_cnt_nxt = r_idle_cnt - 1'b1;
        end
      end

      default: begin
        w_state_nxt = ST_OFF;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (rst_i) begin
      r_state    <= ST_OFF;
      r_wake_cnt <= '0;
      r_idle_cnt <= '0;
      r_clk_en   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wake_cnt <= w_wake_cnt_nxt;
      r_idle_cnt <= w_idle_cnt_nxt;
      // The enable has its own flop instead of being decoded from the two
      // state bits. A WAKE->ON transition flips both bits. A decoder could
      // glitch through OFF and drop the gated clock. This flop always holds
      // (r_state != ST_OFF).
      r_clk_en   <= (w_state_nxt != ST_OFF);
    end
  end

  // ---------------------------------------------------------------------------
  // Gated-cycle statistics: clear has priority, then saturating increment.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i || stat_clr_i) begin
      r_gated <= '0;
    end else if ((r_state == ST_OFF) && (r_gated != '1)) begin
      r_gated <= r_gated + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // Grants are shared, not arbitrated: the clock is common to every client.
  assign gnt_o          = (r_state == ST_ON) ? req_i : '0;
  assign clk_en_o       = r_clk_en;
  assign state_o        = r_state;
  assign gated_cycles_o = r_gated;

endmodule
